// File: rtl/nettlp_eth_rx_decap.sv
// NetTLP receive decapsulator: validates Eth/IPv4/UDP/NetTLP headers on the MAC RX stream
// and forwards the encapsulated TLP qwords to the PCIe TX FIFO. Optional macro: NETTLP_MAC_FILTER_EN.
module nettlp_eth_rx_decap #(
  parameter logic [15:0]  PORT_CPL = 16'h3000,
  parameter logic [15:0]  PORT_MR  = 16'h4000,
  parameter int unsigned  CNT_W    = 16
) (
  input  logic              clk156,
  input  logic              sys_rst_n,
`ifdef NETTLP_MAC_FILTER_EN
  input  logic [47:0]       local_mac,
`endif
  input  logic [63:0]       eth_rx_tdata,
  input  logic [7:0]        eth_rx_tkeep,
  input  logic              eth_rx_tvalid,
  input  logic              eth_rx_tlast,
  input  logic              eth_rx_tuser,
  output logic [78:0]       fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_prog_full,
  output logic [15:0]       nt_seq,
  output logic [31:0]       nt_tstamp,
  output logic              nt_hdr_valid,
  output logic [CNT_W-1:0]  cnt_rx_ok,
  output logic [CNT_W-1:0]  cnt_rx_drop
);

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned KEEP_W   = 8;
  localparam int unsigned BEAT_W   = 3;
  localparam logic [BEAT_W-1:0] HDR_LAST = BEAT_W'(5);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic              data_valid;
    logic              tvalid;
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
    logic [3:0]        tuser;
  } fifo_word_t;

  // Network byte order to PCIe DW order: reverse bytes inside each 32-bit DW.
  function automatic logic [DATA_W-1:0] dw_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 4; b++)
        r[32*w + 8*b +: 8] = d[32*w + 8*(3-b) +: 8];
    return r;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_swap(input logic [KEEP_W-1:0] k);
    logic [KEEP_W-1:0] r;
    r = '0;
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 4; b++)
        r[4*w + b] = k[4*w + (3-b)];
    return r;
  endfunction

  state_t            state, state_d;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
  logic              hdr_ok, hdr_ok_d;
  logic              resync, resync_d;
  logic              inc_ok, inc_drop, accept, wr_d;
  logic              beat_chk, mac_ok;
  fifo_word_t        fifo_word, word_d;

  logic [15:0] ethertype, dport;
  assign ethertype = {eth_rx_tdata[39:32], eth_rx_tdata[47:40]};
  assign dport     = {eth_rx_tdata[39:32], eth_rx_tdata[47:40]};

`ifdef NETTLP_MAC_FILTER_EN
  logic [47:0] dst_mac;
  assign dst_mac = {eth_rx_tdata[7:0],   eth_rx_tdata[15:8],  eth_rx_tdata[23:16],
                    eth_rx_tdata[31:24], eth_rx_tdata[39:32], eth_rx_tdata[47:40]};
  assign mac_ok  = (dst_mac == local_mac) || (dst_mac == 48'hFFFF_FFFF_FFFF);
`else
  assign mac_ok  = 1'b1;
`endif

  // Per-beat header field checks; beats 3 and 5 carry nothing to validate.
  always_comb begin
    beat_chk = 1'b1;
    case (beat_cnt)
      BEAT_W'(1): beat_chk = (ethertype == 16'h0800) && (eth_rx_tdata[55:48] == 8'h45);
      BEAT_W'(2): beat_chk = (eth_rx_tdata[63:56] == 8'h11);
      BEAT_W'(4): beat_chk = (dport == PORT_CPL) || (dport == PORT_MR);
      default:    beat_chk = 1'b1;
    endcase
  end

  always_comb begin
    word_d            = '0;
    word_d.data_valid = 1'b1;
    word_d.tvalid     = 1'b1;
    word_d.tlast      = eth_rx_tlast;
    word_d.tkeep      = keep_swap(eth_rx_tkeep);
    word_d.tdata      = dw_swap(eth_rx_tdata);
    word_d.tuser      = {eth_rx_tuser & eth_rx_tlast, 3'b000};
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d    = state;
    beat_cnt_d = beat_cnt;
    hdr_ok_d   = hdr_ok;
    resync_d   = resync;
    inc_ok     = 1'b0;
    inc_drop   = 1'b0;
    accept     = 1'b0;
    wr_d       = 1'b0;
    case (state)
      IDLE: begin
        if (eth_rx_tvalid) begin
          if (resync) begin
            if (eth_rx_tlast) resync_d = 1'b0;
          end else if (eth_rx_tlast) begin
            inc_drop = 1'b1;
          end else begin
            state_d    = HDR;
            beat_cnt_d = BEAT_W'(1);
            hdr_ok_d   = mac_ok;
          end
        end
      end
      HDR: begin
        if (eth_rx_tvalid) begin
          if (eth_rx_tlast) begin
            inc_drop = 1'b1;
            state_d  = IDLE;
          end else if (beat_cnt == HDR_LAST) begin
            if (hdr_ok && !fifo_prog_full) begin
              state_d = PAYLOAD;
              accept  = 1'b1;
            end else begin
              state_d = DROP;
            end
          end else begin
            beat_cnt_d = beat_cnt + BEAT_W'(1);
            hdr_ok_d   = hdr_ok & beat_chk;
          end
        end
      end
      PAYLOAD: begin
        if (eth_rx_tvalid) begin
          wr_d = 1'b1;
          if (eth_rx_tlast) begin
            state_d = IDLE;
            if (eth_rx_tuser) inc_drop = 1'b1;
            else              inc_ok   = 1'b1;
          end
        end
      end
      DROP: begin
        if (eth_rx_tvalid && eth_rx_tlast) begin
          inc_drop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; during reset, track whether the MAC is mid-frame so the tail is skipped.
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      hdr_ok   <= 1'b0;
      resync   <= eth_rx_tvalid ? !eth_rx_tlast : (resync | (state != IDLE));
    end else begin
      state    <= state_d;
      beat_cnt <= beat_cnt_d;
      hdr_ok   <= hdr_ok_d;
      resync   <= resync_d;
    end
  end

  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_word    <= '0;
      nt_seq       <= '0;
      nt_tstamp    <= '0;
      nt_hdr_valid <= 1'b0;
      cnt_rx_ok    <= '0;
      cnt_rx_drop  <= '0;
    end else begin
      fifo_wr_en   <= wr_d;
      if (wr_d) fifo_word <= word_d;
      nt_hdr_valid <= accept;
      if (accept) begin
        nt_seq    <= {eth_rx_tdata[23:16], eth_rx_tdata[31:24]};
        nt_tstamp <= {eth_rx_tdata[39:32], eth_rx_tdata[47:40],
                      eth_rx_tdata[55:48], eth_rx_tdata[63:56]};
      end
      if (inc_ok && (cnt_rx_ok != '1))     cnt_rx_ok   <= cnt_rx_ok + CNT_W'(1);
      if (inc_drop && (cnt_rx_drop != '1)) cnt_rx_drop <= cnt_rx_drop + CNT_W'(1);
    end
  end

  assign fifo_din = fifo_word;

endmodule

// File: tb/tb_nettlp_eth_rx_decap.sv
// Directed bench for nettlp_eth_rx_decap: header accept/drop, byte swap, gaps, back-pressure, reset.
module tb_nettlp_eth_rx_decap;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic [63:0] eth_rx_tdata;
  logic [7:0]  eth_rx_tkeep;
  logic        eth_rx_tvalid;
  logic        eth_rx_tlast;
  logic        eth_rx_tuser;
  logic [78:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_prog_full;
  logic [15:0] nt_seq;
  logic [31:0] nt_tstamp;
  logic        nt_hdr_valid;
  logic [15:0] cnt_rx_ok;
  logic [15:0] cnt_rx_drop;

  always #5 clk156 = ~clk156;

  nettlp_eth_rx_decap dut (
    .clk156         (clk156),
    .sys_rst_n      (sys_rst_n),
`ifdef NETTLP_MAC_FILTER_EN
    .local_mac      (48'h02_00_00_00_00_01),
`endif
    .eth_rx_tdata   (eth_rx_tdata),
    .eth_rx_tkeep   (eth_rx_tkeep),
    .eth_rx_tvalid  (eth_rx_tvalid),
    .eth_rx_tlast   (eth_rx_tlast),
    .eth_rx_tuser   (eth_rx_tuser),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_prog_full (fifo_prog_full),
    .nt_seq         (nt_seq),
    .nt_tstamp      (nt_tstamp),
    .nt_hdr_valid   (nt_hdr_valid),
    .cnt_rx_ok      (cnt_rx_ok),
    .cnt_rx_drop    (cnt_rx_drop)
  );

  // Expected FIFO words for the standard 16-byte payload (DW-swapped).
  localparam logic [78:0] W_FIRST   = {1'b1, 1'b1, 1'b0, 8'hFF, 64'h0000000F_40000001, 4'h0};
  localparam logic [78:0] W_LAST    = {1'b1, 1'b1, 1'b1, 8'hFF, 64'h00000040_00001000, 4'h0};
  localparam logic [78:0] W_LAST_BD = {1'b1, 1'b1, 1'b1, 8'hFF, 64'h00000040_00001000, 4'h8};
  localparam logic [78:0] W_LAST_62 = {1'b1, 1'b1, 1'b1, 8'hCF, 64'h00000000_00001000, 4'h0};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hdr_pulses = 0;
  logic [78:0] wq[$];
  logic [7:0]  fb [0:127];

  always @(negedge clk156) begin
    if (fifo_wr_en)   wq.push_back(fifo_din);
    if (nt_hdr_valid) hdr_pulses++;
  end

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 79'h0;
  endfunction

  task automatic build(input logic [15:0] dport, input logic [15:0] etype, input logic [7:0] ipver,
                       input logic [15:0] seq, input logic [31:0] ts);
    logic [7:0] pay [0:15] = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0F,
                               8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    for (int i = 0; i < 128; i++) fb[i] = 8'(i);
    for (int i = 0; i < 6; i++)   fb[i] = 8'hFF;
    fb[12] = etype[15:8]; fb[13] = etype[7:0];
    fb[14] = ipver;
    fb[23] = 8'h11;
    fb[36] = dport[15:8]; fb[37] = dport[7:0];
    fb[42] = seq[15:8];   fb[43] = seq[7:0];
    fb[44] = ts[31:24]; fb[45] = ts[23:16]; fb[46] = ts[15:8]; fb[47] = ts[7:0];
    for (int i = 0; i < 16; i++) fb[48+i] = pay[i];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk156);
      eth_rx_tvalid = 1'b0; eth_rx_tlast = 1'b0; eth_rx_tuser = 1'b0;
      eth_rx_tdata = '0; eth_rx_tkeep = '0;
    end
  endtask

  // Drives fb[0..nbytes-1]; optional 3-cycle gap before beat gap_beat, reset held over beats rst_beat..rst_beat+1.
  task automatic send(input int nbytes, input bit bad, input int gap_beat, input int rst_beat);
    int nb;
    nb = (nbytes + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      if (k == gap_beat) idle(3);
      @(negedge clk156);
      if (k == rst_beat)     sys_rst_n = 1'b0;
      if (k == rst_beat + 2) sys_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        eth_rx_tdata[8*i +: 8] = (8*k + i < nbytes) ? fb[8*k + i] : 8'h00;
        eth_rx_tkeep[i]        = (8*k + i < nbytes);
      end
      eth_rx_tvalid = 1'b1;
      eth_rx_tlast  = (k == nb - 1);
      eth_rx_tuser  = bad && (k == nb - 1);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; fifo_prog_full = 1'b0;
    eth_rx_tvalid = 1'b0; eth_rx_tlast = 1'b0; eth_rx_tuser = 1'b0;
    eth_rx_tdata = '0; eth_rx_tkeep = '0;
    idle(4);
    sys_rst_n = 1'b1;
    idle(2);
    chk("rst_wr_en",  79'(fifo_wr_en),   79'h0);
    chk("rst_din",    fifo_din,          79'h0);
    chk("rst_seq",    79'(nt_seq),       79'h0);
    chk("rst_ts",     79'(nt_tstamp),    79'h0);
    chk("rst_hvalid", 79'(nt_hdr_valid), 79'h0);
    chk("rst_ok",     79'(cnt_rx_ok),    79'h0);
    chk("rst_drop",   79'(cnt_rx_drop),  79'h0);

    // Valid MR frame, 8 beats
    build(16'h4000, 16'h0800, 8'h45, 16'h0005, 32'h11223344);
    send(64, 1'b0, -1, -1);
    idle(4);
    chk("t1_wr_cnt", 79'(wq.size()),  79'd2);
    chk("t1_word0",  wq_at(0),        W_FIRST);
    chk("t1_word1",  wq_at(1),        W_LAST);
    chk("t1_seq",    79'(nt_seq),     79'h0005);
    chk("t1_ts",     79'(nt_tstamp),  79'h11223344);
    chk("t1_pulses", 79'(hdr_pulses), 79'd1);
    chk("t1_ok",     79'(cnt_rx_ok),  79'd1);
    chk("t1_drop",   79'(cnt_rx_drop),79'd0);

    // Bad dport, bad ethertype, bad IP version/IHL
    build(16'h5000, 16'h0800, 8'h45, 16'h0005, 32'h11223344); send(64, 1'b0, -1, -1);
    build(16'h4000, 16'h86DD, 8'h45, 16'h0005, 32'h11223344); send(64, 1'b0, -1, -1);
    build(16'h4000, 16'h0800, 8'h46, 16'h0005, 32'h11223344); send(64, 1'b0, -1, -1);
    idle(4);
    chk("t2_wr_cnt", 79'(wq.size()),   79'd2);
    chk("t2_drop",   79'(cnt_rx_drop), 79'd3);
    chk("t2_ok",     79'(cnt_rx_ok),   79'd1);
    chk("t2_pulses", 79'(hdr_pulses),  79'd1);

    // Completion port, bad FCS on last beat
    build(16'h3000, 16'h0800, 8'h45, 16'h0007, 32'hA5A50001);
    send(64, 1'b1, -1, -1);
    idle(4);
    chk("t3_wr_cnt", 79'(wq.size()),   79'd4);
    chk("t3_last",   wq_at(3),         W_LAST_BD);
    chk("t3_seq",    79'(nt_seq),      79'h0007);
    chk("t3_ts",     79'(nt_tstamp),   79'hA5A50001);
    chk("t3_ok",     79'(cnt_rx_ok),   79'd1);
    chk("t3_drop",   79'(cnt_rx_drop), 79'd4);

    // prog_full at decision, then back-to-back 62-byte frame with payload gaps
    fifo_prog_full = 1'b1;
    build(16'h4000, 16'h0800, 8'h45, 16'h0005, 32'h11223344);
    send(64, 1'b0, -1, -1);
    fifo_prog_full = 1'b0;
    build(16'h4000, 16'h0800, 8'h45, 16'h0009, 32'hCAFEF00D);
    send(62, 1'b0, 7, -1);
    idle(4);
    chk("t4_wr_cnt", 79'(wq.size()),   79'd6);
    chk("t4_word0",  wq_at(4),         W_FIRST);
    chk("t4_word1",  wq_at(5),         W_LAST_62);
    chk("t4_seq",    79'(nt_seq),      79'h0009);
    chk("t4_ts",     79'(nt_tstamp),   79'hCAFEF00D);
    chk("t4_ok",     79'(cnt_rx_ok),   79'd2);
    chk("t4_drop",   79'(cnt_rx_drop), 79'd5);

    // Header-only, single-beat and truncated-header frames
    send(48, 1'b0, -1, -1);
    send(8,  1'b0, -1, -1);
    send(30, 1'b0, -1, -1);
    idle(4);
    chk("t5_wr_cnt", 79'(wq.size()),   79'd6);
    chk("t5_drop",   79'(cnt_rx_drop), 79'd8);
    chk("t5_ok",     79'(cnt_rx_ok),   79'd2);

    // Reset during payload beat 2, then a clean frame
    send(96, 1'b0, -1, 8);
    idle(4);
    chk("t6_wr_cnt", 79'(wq.size()),   79'd8);
    chk("t6_ok",     79'(cnt_rx_ok),   79'd0);
    chk("t6_drop",   79'(cnt_rx_drop), 79'd0);
    chk("t6_seq",    79'(nt_seq),      79'h0);
    chk("t6_ts",     79'(nt_tstamp),   79'h0);
    send(64, 1'b0, -1, -1);
    idle(4);
    chk("t6b_wr_cnt", 79'(wq.size()),  79'd10);
    chk("t6b_last",   wq_at(9),        W_LAST);
    chk("t6b_ok",     79'(cnt_rx_ok),  79'd1);
    chk("t6b_seq",    79'(nt_seq),     79'h0009);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nettlp_eth_rx_decap.md
Name: nettlp_eth_rx_decap

Overview:
- Receive-side NetTLP decapsulator; the inverse of the Ethernet TX packet builder.
- Consumes 64-bit AXI-Stream frames from the 10G Ethernet MAC RX, validates the Eth/IPv4/UDP/NetTLP header (6 qwords, 48 bytes) and extracts the NetTLP seq/timestamp.
- Writes the encapsulated TLP qwords into the PCIE_TX FIFO (PCIE_FIFO64_TX format, 79 bits) for injection into the PCIe core.
- Non-NetTLP, short, or overflow-risk frames are dropped whole.

Parameters:
- PORT_CPL, 16'h3000, UDP dest port accepted for completions
- PORT_MR, 16'h4000, UDP dest port accepted for memory requests
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk156  in  1  Ethernet user clock
- sys_rst_n  in  1  reset; synchronous to clk156, active-low
- eth_rx_tdata  in  64  MAC RX data; frame byte 8k+i at beat k, bits [8i+7:8i]
- eth_rx_tkeep  in  8  byte enables (contiguous from bit 0)
- eth_rx_tvalid  in  1  beat valid (MAC has no tready)
- eth_rx_tlast  in  1  last beat of frame
- eth_rx_tuser  in  1  on tlast: 1 = bad frame (FCS/phy error)
- fifo_din  out  79  {data_valid, tvalid, tlast, tkeep[7:0], tdata[63:0], tuser[3:0]}
- fifo_wr_en  out  1  FIFO write strobe
- fifo_prog_full  in  1  FIFO programmable-full, room for ≥1 max frame when low
- nt_seq  out  16  raw NetTLP bytes 42-43 of last accepted frame (reserved:6, seq:10)
- nt_tstamp  out  32  NetTLP timestamp of last accepted frame
- nt_hdr_valid  out  1  1-cycle pulse when nt_seq/nt_tstamp update
- cnt_rx_ok  out  CNT_W  accepted frames, saturating
- cnt_rx_drop  out  CNT_W  dropped frames, saturating

Behaviour:
- Reset (sys_rst_n=0 at clk156 edge): state IDLE; fifo_wr_en=0, fifo_din=0, nt_seq=0, nt_tstamp=0, nt_hdr_valid=0, counters=0. A frame in progress is abandoned; after release, beats are ignored until the next tlast, then IDLE.
- FSM states: IDLE, HDR, PAYLOAD, DROP.
- IDLE: on tvalid, capture beat 0 and go to HDR with beat counter = 1. If tvalid&tlast on beat 0, count drop and stay IDLE.
- HDR: capture beats 1..5. Checks, in network byte order:
  - ethertype bytes 12-13 = 08 00
  - byte 14 = 0x45
  - IP protocol byte 23 = 0x11
  - UDP dest port bytes 36-37 ∈ {PORT_CPL, PORT_MR}
- Check results are registered per beat. Decision is made at beat 5.
  - tlast at any header beat → drop, back to IDLE.
  - Beat 5 fails any check or fifo_prog_full=1 → DROP.
  - Otherwise → PAYLOAD; latch nt_seq (beat5 bytes 2-3) and nt_tstamp (beat5 bytes 4-7, byte 44 MSB); pulse nt_hdr_valid.
- No FIFO write ever occurs for header beats or dropped frames.
- PAYLOAD: each valid beat is written one cycle later (latency 1).
  - tdata: bytes swapped within each 32-bit DW (network → PCIe DW order).
  - tkeep: swapped per DW to match.
  - tlast = eth tlast; tvalid = 1; data_valid = 1; tuser = 4'b0000, except tuser[3] = 1 (discontinue) on the last beat when eth_rx_tuser = 1.
  - On tlast, go to IDLE: eth_rx_tuser = 0 → cnt_rx_ok+1; eth_rx_tuser = 1 → cnt_rx_drop+1.
- DROP: consume beats until tlast, then cnt_rx_drop+1 and go to IDLE.
- Gaps: tvalid=0 cycles are legal in any state; the FSM holds state.
- Counters saturate at all-ones; there is no wrap.
- fifo_prog_full is sampled only at the beat-5 decision; mid-frame assertion does not truncate the frame.
- A frame ending exactly at beat 5 (48 bytes, no TLP) is dropped.

Optional Feature:
- Macro NETTLP_MAC_FILTER_EN.
- Defined: adds input port local_mac [47:0]. Frame dest MAC (bytes 0-5) must equal local_mac or be ff:ff:ff:ff:ff:ff, else the frame is dropped (counted in cnt_rx_drop).
- Undefined: no port; dest MAC is ignored.

Test Plan:
- Valid MR frame, UDP dport 0x4000, seq bytes 00 05, tstamp 0x11223344, 3DW TLP + 1DW data (8 beats total) → 2 FIFO writes, last with tlast=1, tkeep=0xFF; nt_seq=0x0005, nt_tstamp=0x11223344; cnt_rx_ok=1.
- Same frame with dport 0x5000, then ethertype 0x86DD, then IP byte 0x46 → zero FIFO writes; cnt_rx_drop=3.
- Valid frame with eth_rx_tuser=1 on tlast → payload written, last beat tuser=4'b1000; cnt_rx_drop=1, cnt_rx_ok=0.
- fifo_prog_full=1 at beat 5 → no writes. Deassert, then send a back-to-back valid frame → written normally.
- Payload DW bytes 0x00,0x00,0x00,0x40 (network order) → tdata DW = 0x00000040 after swap; tvalid gaps inserted mid-payload → write count unchanged.
- Assert sys_rst_n=0 at payload beat 2 and release → no further writes until the next frame after tlast; outputs and counters 0.
